alu_result_byte_sender: RTL and testbench
=========================================

Name: alu_result_byte_sender

Overview:
- Consumer end of the ALU shift path: accepts a full-width result qualified by a one-cycle valid flag (the Shift_OUT/Shift_Flag pair) and streams it out as bytes over a valid/ready handshake toward the UART TX framing logic.
- Buffers one result in flight plus one pending result, so back-to-back ALU operations are not lost while bytes drain.
- Sits between the ALU output register and the TX byte interface in the system datapath.

Parameters:
- DATA_WIDTH, 16, width of the ALU result; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one transmitted unit.
- MSB_FIRST, 0, 0 = least-significant byte sent first; 1 = most-significant byte sent first.
- Derived localparam NUM_BYTES = DATA_WIDTH/BYTE_WIDTH (2 by default).

Ports:
- CLK  in  1  system clock, rising-edge active.
- RST  in  1  reset, synchronous, active-high.
- ALU_OUT  in  DATA_WIDTH  result word; sampled only when OUT_VALID=1.
- OUT_VALID  in  1  one-cycle strobe marking a new result.
- TX_DATA  out  BYTE_WIDTH  current byte.
- TX_VALID  out  1  TX_DATA holds a valid byte.
- TX_READY  in  1  downstream accepts the byte on the rising edge when TX_VALID=1.
- BUSY  out  1  pending slot full; a new OUT_VALID in this state is dropped.
- OVERRUN  out  1  sticky: a result was dropped.
- CLR_OVR  in  1  clears OVERRUN.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State goes to IDLE.
  - Shift register, pending register, byte counter and pending-valid flag clear.
  - TX_DATA=0, TX_VALID=0, BUSY=0, OVERRUN=0.
  - Reset mid-transfer abandons the in-flight and pending words; no further bytes are emitted.
- All outputs are registered. TX_DATA always reflects the selected byte of the shift register.
- States:
  - IDLE: TX_VALID=0. OUT_VALID=1 loads ALU_OUT into the shift register and clears the byte counter; next state SEND. TX_VALID=1 and byte 0 appear on the cycle after OUT_VALID (latency 1).
  - SEND: TX_VALID=1. A transfer occurs on an edge with TX_VALID&TX_READY, and the counter increments.
    - While TX_READY=0, TX_DATA and TX_VALID hold stable.
- Last-byte accept (counter = NUM_BYTES-1 and transfer):
  - Pending-valid=1: pending word moves to the shift register, counter clears, state stays SEND, TX_VALID stays 1 (zero-bubble). If OUT_VALID=1 in the same cycle, the new word enters the pending slot.
  - Pending-valid=0 and OUT_VALID=1: ALU_OUT loads straight into the shift register; stay in SEND with no bubble.
  - Otherwise: go to IDLE, TX_VALID=0 next cycle.
- OUT_VALID in SEND, not on a last-byte accept:
  - Pending empty: capture into pending; BUSY=1 next cycle.
  - Pending full: word dropped, OVERRUN=1 next cycle; pending keeps the older word.
- BUSY=1 exactly while pending-valid=1.
- OVERRUN:
  - CLR_OVR=1 clears it next cycle.
  - If CLR_OVR and a drop happen in the same cycle, set wins.
- Byte selection:
  - MSB_FIRST=0: byte k = bits [k*BYTE_WIDTH +: BYTE_WIDTH].
  - MSB_FIRST=1: byte k = bits [(NUM_BYTES-1-k)*BYTE_WIDTH +: BYTE_WIDTH].
- The counter is clog2(NUM_BYTES) bits wide (minimum 1) and never exceeds NUM_BYTES-1.
- No combinational path from TX_READY to TX_VALID or TX_DATA.

Decomposition:
- Shared package/include: state encodings (IDLE=1'b0, SEND=1'b1) and the default DATA_WIDTH/BYTE_WIDTH constants shared with the ALU and the UART TX block.
- One natural sub-module: alu_result_slot, the pending holding register with valid/BUSY, load/take controls and overrun detection.
- Sequencing and byte mux stay in the top-level module.

Test Plan:
- Reset, then OUT_VALID with ALU_OUT=16'hA55A, TX_READY=1 -> TX_VALID rises next cycle; TX_DATA=8'h5A then 8'hA5 on consecutive cycles; TX_VALID falls after.
- 16'h1234, TX_READY held 0 for 5 cycles then 1 -> TX_DATA stays 8'h34 with TX_VALID=1 throughout the stall, then 8'h34, 8'h12 transfer.
- 16'h1111, then 16'h2222 one cycle later, TX_READY=1 -> BUSY pulses; bytes 11,11,22,22 stream with TX_VALID continuously high (no bubble).
- Three strobes 16'h0001, 16'h0002, 16'h0003 while TX_READY=0 -> OVERRUN=1 after the third; release TX_READY -> bytes 01,00,02,00 only; CLR_OVR pulse -> OVERRUN=0.
- RST asserted after the first byte of 16'hBEEF is accepted -> next cycle TX_VALID=0, TX_DATA=0, BUSY=0; 8'hBE is never sent.
- MSB_FIRST=1, DATA_WIDTH=32, 32'hDEADBEEF -> bytes DE, AD, BE, EF in order.

Source files
------------

// File: rtl/alu_result_byte_sender_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_byte_sender_pkg
//
// Purpose: constants and types shared by the ALU result byte sender, the ALU
// output stage and the UART TX framing block.
//
// Contents:
//   DEFAULT_DATA_WIDTH  default ALU result width (16)
//   DEFAULT_BYTE_WIDTH  default transmitted unit width (8)
//   senderState_e       sequencer state encoding (IDLE / SEND)
//   countWidth()        byte counter width for a given byte count (min 1)
// ---------------------------------------------------------------------------
package alu_result_byte_sender_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_BYTE_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } senderState_e;

    // A single-byte word still needs a one-bit counter so the port exists.
    function automatic int countWidth(input int numBytes);
        return (numBytes > 1) ? $clog2(numBytes) : 1;
    endfunction

endpackage

// File: rtl/alu_result_byte_sender_if.sv
// ---------------------------------------------------------------------------
// alu_result_byte_sender_if
//
// Purpose: bundles the ALU result strobe and the TX byte handshake of the
// ALU result byte sender.
//
// Signals:
//   ALU_OUT    [DATA_WIDTH]  result word, meaningful when OUT_VALID=1
//   OUT_VALID                one-cycle strobe marking a new result
//   TX_DATA    [BYTE_WIDTH]  current byte toward UART TX
//   TX_VALID                 TX_DATA holds a valid byte
//   TX_READY                 downstream accepts the byte this edge
//   BUSY                     pending slot is full
//   OVERRUN                  sticky: a result was dropped
//   CLR_OVR                  clears OVERRUN
//
// Modports:
//   slave   the byte sender itself
//   master  the surrounding system (ALU side + TX side)
// ---------------------------------------------------------------------------
interface alu_result_byte_sender_if
    import alu_result_byte_sender_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH
) ();

    logic [DATA_WIDTH-1:0] ALU_OUT;
    logic                  OUT_VALID;
    logic [BYTE_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic                  BUSY;
    logic                  OVERRUN;
    logic                  CLR_OVR;

    modport slave (
        input  ALU_OUT,
        input  OUT_VALID,
        input  TX_READY,
        input  CLR_OVR,
        output TX_DATA,
        output TX_VALID,
        output BUSY,
        output OVERRUN
    );

    modport master (
        output ALU_OUT,
        output OUT_VALID,
        output TX_READY,
        output CLR_OVR,
        input  TX_DATA,
        input  TX_VALID,
        input  BUSY,
        input  OVERRUN
    );

endinterface

// File: rtl/alu_result_slot.sv
// ---------------------------------------------------------------------------
// alu_result_slot
//
// Purpose: single-entry holding register for an ALU result that arrives
// while the previous result is still being serialised. Tracks occupancy and
// raises a sticky overrun flag when a result has to be dropped.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   load_i     offer word_i to the slot this cycle
//   take_i     sequencer consumes the held word this cycle
//   clrOvr_i   clear the overrun flag
//   word_i     incoming result word
//   word_o     held result word
//   valid_o    slot occupied (drives BUSY)
//   overrun_o  sticky overrun flag
// ---------------------------------------------------------------------------
module alu_result_slot
    import alu_result_byte_sender_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  take_i,
    input  logic                  clrOvr_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  valid_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  drop;

    // A load only fails when the slot is full and is not being emptied in
    // the same cycle; a simultaneous take frees the slot for the new word.
    assign drop = load_i && valid_q && !take_i;

    // Next-state for the slot; a drop keeps the older word and beats a clear.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (take_i) begin
            valid_d = 1'b0;
        end
        if (load_i && !drop) begin
            word_d  = word_i;
            valid_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clrOvr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/alu_result_byte_sender.sv
// ---------------------------------------------------------------------------
// alu_result_byte_sender
//
// Purpose: takes full-width ALU results qualified by a one-cycle strobe and
// streams them out byte by byte over a valid/ready handshake toward the UART
// TX framing logic. One word is serialised from the shift register while one
// more can wait in the pending slot; back-to-back words go out with no gap.
//
// Ports:
//   CLK   system clock, rising edge
//   RST   synchronous active-high reset
//   bus   slave side of alu_result_byte_sender_if (ALU_OUT/OUT_VALID in,
//         TX_DATA/TX_VALID out, TX_READY in, BUSY/OVERRUN out, CLR_OVR in)
//
// Parameters:
//   DATA_WIDTH  result width, a multiple of BYTE_WIDTH
//   BYTE_WIDTH  transmitted unit width
//   MSB_FIRST   0 = least-significant byte first, 1 = most-significant first
// ---------------------------------------------------------------------------
module alu_result_byte_sender
    import alu_result_byte_sender_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH,
    parameter int MSB_FIRST  = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    alu_result_byte_sender_if.slave  bus
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W     = countWidth(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    senderState_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [BYTE_WIDTH-1:0] txData_q, txData_d;
    logic                  txValid_q, txValid_d;

    logic                  slotLoad;
    logic                  slotTake;
    logic [DATA_WIDTH-1:0] slotWord;
    logic                  slotValid;
    logic                  slotOverrun;

    // Byte k of a word in transmission order.
    function automatic logic [BYTE_WIDTH-1:0] selectByte(
        input logic [DATA_WIDTH-1:0] word,
        input logic [CNT_W-1:0]      k
    );
        logic [BYTE_WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (k == CNT_W'(i)) begin
                if (MSB_FIRST != 0) begin
                    result = word[(NUM_BYTES-1-i)*BYTE_WIDTH +: BYTE_WIDTH];
                end else begin
                    result = word[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        return result;
    endfunction

    alu_result_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
        .clk_i     (CLK),
        .rst_i     (RST),
        .load_i    (slotLoad),
        .take_i    (slotTake),
        .clrOvr_i  (bus.CLR_OVR),
        .word_i    (bus.ALU_OUT),
        .word_o    (slotWord),
        .valid_o   (slotValid),
        .overrun_o (slotOverrun)
    );

    // Sequencer next state. On the last byte of a word the next word comes
    // from the pending slot if it holds one, otherwise straight from the ALU
    // strobe, so TX_VALID never drops between back-to-back words. The TX
    // outputs are registered copies of the next shift/count, which keeps
    // TX_READY off any combinational path to TX_VALID or TX_DATA.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        slotLoad = 1'b0;
        slotTake = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.OUT_VALID) begin
                    shift_d = bus.ALU_OUT;
                    count_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.TX_READY && count_q == LAST_IDX) begin
                    count_d = '0;
                    if (slotValid) begin
                        shift_d  = slotWord;
                        slotTake = 1'b1;
                        slotLoad = bus.OUT_VALID;
                    end else if (bus.OUT_VALID) begin
                        shift_d = bus.ALU_OUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.TX_READY) begin
                        count_d = count_q + 1'b1;
                    end
                    slotLoad = bus.OUT_VALID;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        txValid_d = (state_d == SEND);
        txData_d  = selectByte(shift_d, count_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            txData_q  <= '0;
            txValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            txData_q  <= txData_d;
            txValid_q <= txValid_d;
        end
    end

    assign bus.TX_DATA  = txData_q;
    assign bus.TX_VALID = txValid_q;
    assign bus.BUSY     = slotValid;
    assign bus.OVERRUN  = slotOverrun;

endmodule

// File: tb/tb_alu_result_byte_sender.sv
// ---------------------------------------------------------------------------
// tb_alu_result_byte_sender
//
// Drives two sender instances from the same stimulus: a default 16-bit,
// LSB-first instance and a 32-bit, MSB-first instance. A word-queue
// reference model predicts TX_VALID, TX_DATA, BUSY and OVERRUN every cycle;
// directed scenarios add checks against hand-computed byte values.
// ---------------------------------------------------------------------------
module tb_alu_result_byte_sender;

    logic clk;
    logic rst;

    int compareCount  = 0;
    int mismatchCount = 0;

    alu_result_byte_sender_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8)) bus16 ();
    alu_result_byte_sender_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus32 ();

    alu_result_byte_sender #(
        .DATA_WIDTH (16),
        .BYTE_WIDTH (8),
        .MSB_FIRST  (0)
    ) dut16 (
        .CLK (clk),
        .RST (rst),
        .bus (bus16.slave)
    );

    alu_result_byte_sender #(
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .MSB_FIRST  (1)
    ) dut32 (
        .CLK (clk),
        .RST (rst),
        .bus (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance holds up to two words (in flight,
    // pending) and an index of the next byte to transmit from the first one.
    logic [31:0] mWord [2][2];
    int          mCnt  [2];
    int          mIdx  [2];
    logic        mOvr  [2];
    int          mNum  [2] = '{2, 4};
    bit          mMsb  [2] = '{1'b0, 1'b1};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelByte(input int d);
        int shiftBy;
        logic [31:0] w;
        w = mWord[d][0];
        shiftBy = mMsb[d] ? (mNum[d] - 1 - mIdx[d]) * 8 : mIdx[d] * 8;
        return 8'(w >> shiftBy);
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mCnt[d] = 0;
            mIdx[d] = 0;
            mOvr[d] = 1'b0;
            mWord[d][0] = '0;
            mWord[d][1] = '0;
        end
    endtask

    task automatic modelUpdate(input bit ov, input logic [31:0] data,
                               input bit rdy, input bit clr);
        bit dropped;
        logic [31:0] w;
        for (int d = 0; d < 2; d++) begin
            w = (d == 0) ? (data & 32'h0000_FFFF) : data;
            dropped = 1'b0;
            if (mCnt[d] > 0 && rdy) begin
                mIdx[d]++;
                if (mIdx[d] == mNum[d]) begin
                    mWord[d][0] = mWord[d][1];
                    mCnt[d]--;
                    mIdx[d] = 0;
                end
            end
            if (ov) begin
                if (mCnt[d] < 2) begin
                    mWord[d][mCnt[d]] = w;
                    mCnt[d]++;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) mOvr[d] = 1'b1;
            else if (clr) mOvr[d] = 1'b0;
        end
    endtask

    task automatic modelCompare();
        checkOutput("txValid16", 32'(bus16.TX_VALID), 32'(mCnt[0] > 0));
        checkOutput("busy16",    32'(bus16.BUSY),     32'(mCnt[0] == 2));
        checkOutput("overrun16", 32'(bus16.OVERRUN),  32'(mOvr[0]));
        if (mCnt[0] > 0) checkOutput("txData16", 32'(bus16.TX_DATA), 32'(modelByte(0)));
        checkOutput("txValid32", 32'(bus32.TX_VALID), 32'(mCnt[1] > 0));
        checkOutput("busy32",    32'(bus32.BUSY),     32'(mCnt[1] == 2));
        checkOutput("overrun32", 32'(bus32.OVERRUN),  32'(mOvr[1]));
        if (mCnt[1] > 0) checkOutput("txData32", 32'(bus32.TX_DATA), 32'(modelByte(1)));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model,
    // then compare at the following falling edge.
    task automatic applyStimulus(input bit ov, input logic [31:0] data,
                                 input bit rdy, input bit clr, input bit doRst);
        rst             = doRst;
        bus16.OUT_VALID = ov;
        bus32.OUT_VALID = ov;
        bus16.ALU_OUT   = data[15:0];
        bus32.ALU_OUT   = data;
        bus16.TX_READY  = rdy;
        bus32.TX_READY  = rdy;
        bus16.CLR_OVR   = clr;
        bus32.CLR_OVR   = clr;
        @(posedge clk);
        if (doRst) modelReset();
        else modelUpdate(ov, data, rdy, clr);
        @(negedge clk);
        modelCompare();
    endtask

    initial begin
        rst             = 1'b1;
        bus16.OUT_VALID = 1'b0;
        bus32.OUT_VALID = 1'b0;
        bus16.ALU_OUT   = '0;
        bus32.ALU_OUT   = '0;
        bus16.TX_READY  = 1'b0;
        bus32.TX_READY  = 1'b0;
        bus16.CLR_OVR   = 1'b0;
        bus32.CLR_OVR   = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rstData16", 32'(bus16.TX_DATA), 32'h0);
        checkOutput("rstValid16", 32'(bus16.TX_VALID), 32'h0);
        checkOutput("rstOvr16", 32'(bus16.OVERRUN), 32'h0);

        // A55A, ready held high: 5A then A5, then idle
        applyStimulus(1, 32'h0000_A55A, 1, 0, 0);
        checkOutput("a55aByte0", 32'(bus16.TX_DATA), 32'h5A);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("a55aByte1", 32'(bus16.TX_DATA), 32'hA5);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("a55aIdle", 32'(bus16.TX_VALID), 32'h0);

        // 1234 with a 5-cycle stall
        applyStimulus(1, 32'h0000_1234, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stallData", 32'(bus16.TX_DATA), 32'h34);
        checkOutput("stallValid", 32'(bus16.TX_VALID), 32'h1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("stallByte1", 32'(bus16.TX_DATA), 32'h12);
        repeat (4) applyStimulus(0, 0, 1, 0, 0);

        // Back-to-back words, no bubble
        applyStimulus(1, 32'h0000_1111, 1, 0, 0);
        applyStimulus(1, 32'h0000_2222, 1, 0, 0);
        checkOutput("b2bBusy", 32'(bus16.BUSY), 32'h1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("b2bSecond", 32'(bus16.TX_DATA), 32'h22);
        checkOutput("b2bNoGap", 32'(bus16.TX_VALID), 32'h1);
        repeat (6) applyStimulus(0, 0, 1, 0, 0);

        // Three strobes while stalled: third is dropped
        applyStimulus(1, 32'h0000_0001, 0, 0, 0);
        applyStimulus(1, 32'h0000_0002, 0, 0, 0);
        applyStimulus(1, 32'h0000_0003, 0, 0, 0);
        checkOutput("ovrSet", 32'(bus16.OVERRUN), 32'h1);
        repeat (6) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("ovrSticky", 32'(bus16.OVERRUN), 32'h1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("ovrClear", 32'(bus16.OVERRUN), 32'h0);

        // Reset after the first byte of BEEF was accepted
        applyStimulus(1, 32'h0000_BEEF, 1, 0, 0);
        checkOutput("beefByte0", 32'(bus16.TX_DATA), 32'hEF);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("midRstValid", 32'(bus16.TX_VALID), 32'h0);
        checkOutput("midRstData", 32'(bus16.TX_DATA), 32'h0);
        checkOutput("midRstBusy", 32'(bus16.BUSY), 32'h0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);

        // MSB-first 32-bit word
        applyStimulus(1, 32'hDEAD_BEEF, 1, 0, 0);
        checkOutput("msbByte0", 32'(bus32.TX_DATA), 32'hDE);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("msbByte1", 32'(bus32.TX_DATA), 32'hAD);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("msbByte2", 32'(bus32.TX_DATA), 32'hBE);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("msbByte3", 32'(bus32.TX_DATA), 32'hEF);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(99) < 30,
                          $urandom,
                          $urandom_range(99) < 60,
                          $urandom_range(99) < 5,
                          $urandom_range(999) < 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
